// File: rtl/cordic_vec_iter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : cordic_vec_iter_ctrl
//  Brief    : Folded CORDIC vectoring engine, one shift-add stage reused for
//             NUM_ITER micro-rotations; returns scaled magnitude + direction bits.
//  Revision : 1.0  initial release
// ============================================================================
module cordic_vec_iter_ctrl #(
    parameter int CORDIC_WIDTH = 22,
    parameter int NUM_ITER     = 16
) (
    input  logic                           clk,
    input  logic                           nreset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic signed [CORDIC_WIDTH-1:0] x_in,
    input  logic signed [CORDIC_WIDTH-1:0] y_in,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic signed [CORDIC_WIDTH-1:0] x_out,
    output logic        [NUM_ITER-1:0]     dir_out,
    output logic                           quad_flip,
    output logic                           busy
);

    localparam int CNT_W = $clog2(NUM_ITER);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(NUM_ITER - 1);
    localparam logic signed [CORDIC_WIDTH-1:0] c_min_neg = {1'b1, {(CORDIC_WIDTH-1){1'b0}}};
    localparam logic signed [CORDIC_WIDTH-1:0] c_max_pos = {1'b0, {(CORDIC_WIDTH-1){1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PRE  = 2'd1,
        S_ITER = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    logic signed [CORDIC_WIDTH-1:0] r_x;
    logic signed [CORDIC_WIDTH-1:0] r_y;
    logic        [CNT_W-1:0]        r_cnt;
    logic        [NUM_ITER-1:0]     r_dir;
    logic                           r_flip;

    logic signed [CORDIC_WIDTH-1:0] w_x_neg;
    logic signed [CORDIC_WIDTH-1:0] w_y_neg;
    logic signed [CORDIC_WIDTH-1:0] w_x_sh;
    logic signed [CORDIC_WIDTH-1:0] w_y_sh;
    logic                           w_load;

    // The most negative value has no positive counterpart, so it saturates.
    assign w_x_neg = (r_x == c_min_neg) ? c_max_pos : -r_x;
    assign w_y_neg = (r_y == c_min_neg) ? c_max_pos : -r_y;
    assign w_x_sh  = r_x >>> r_cnt;
    assign w_y_sh  = r_y >>> r_cnt;

    // Results are registered on the first DONE cycle only; later cycles just hold.
    assign w_load   = (r_state == S_DONE) && !out_valid;
    assign in_ready = (r_state == S_IDLE);
    assign busy     = (r_state != S_IDLE);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_next = S_PRE;
            S_PRE:   w_next = S_ITER;
            S_ITER:  if (r_cnt == c_last) w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_x    <= '0;
            r_y    <= '0;
            r_cnt  <= '0;
            r_dir  <= '0;
            r_flip <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_x <= x_in;
                        r_y <= y_in;
                    end
                end
                S_PRE: begin
                    r_cnt <= '0;
                    r_dir <= '0;
                    if (r_x[CORDIC_WIDTH-1]) begin
                        r_x    <= w_x_neg;
                        r_y    <= w_y_neg;
                        r_flip <= 1'b1;
                    end else begin
                        r_flip <= 1'b0;
                    end
                end
                S_ITER: begin
                    if (r_y[CORDIC_WIDTH-1]) begin
                        r_x <= r_x - w_y_sh;
                        r_y <= r_y + w_x_sh;
                    end else begin
                        r_x <= r_x + w_y_sh;
                        r_y <= r_y - w_x_sh;
                    end
                    r_dir[r_cnt] <= r_y[CORDIC_WIDTH-1];
                    if (r_cnt != c_last) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // With out_ready already high the result leaves as a one-cycle pulse.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            out_valid <= 1'b0;
            x_out     <= '0;
            dir_out   <= '0;
            quad_flip <= 1'b0;
        end else begin
            if (w_load) begin
                out_valid <= 1'b1;
                x_out     <= r_x;
                dir_out   <= r_dir;
                quad_flip <= r_flip;
            end else if ((r_state != S_DONE) || out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cordic_vec_iter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cordic_vec_iter_ctrl
//  Brief    : Directed self-checking bench for cordic_vec_iter_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cordic_vec_iter_ctrl;

    localparam int W = 22;
    localparam int N = 16;

    logic                clk;
    logic                nreset;
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] x_in;
    logic signed [W-1:0] y_in;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] x_out;
    logic        [N-1:0] dir_out;
    logic                quad_flip;
    logic                busy;

    int n_vec  = 0;
    int n_fail = 0;

    cordic_vec_iter_ctrl #(.CORDIC_WIDTH(W), .NUM_ITER(N)) dut (
        .clk       (clk),
        .nreset    (nreset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .y_in      (y_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x_out     (x_out),
        .dir_out   (dir_out),
        .quad_flip (quad_flip),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_tol(input string tag, input int obs, input int exp, input int tol);
        n_vec++;
        assert ((obs >= exp - tol) && (obs <= exp + tol)) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d +-%0d", tag, obs, exp, tol);
        end
    endtask

    // Drives one request; returns 1ns after the accept edge.
    task automatic start_op(input int x, input int y);
        @(negedge clk);
        x_in     = W'(x);
        y_in     = W'(y);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Counts edges after the accept edge until out_valid is seen (bounded).
    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        int acc_cyc[$];
        int res_cnt;
        int last_acc;
        logic acc;
        logic signed [W-1:0] xs;
        logic [N-1:0] ds;

        nreset    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        x_in      = '0;
        y_in      = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        nreset = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_x_out",     x_out,     0);
        chk("rst_dir_out",   dir_out,   0);
        chk("rst_quad_flip", quad_flip, 0);
        chk("rst_busy",      busy,      0);
        chk("rst_in_ready",  in_ready,  1);

        // (1000,0): magnitude 1000*K, dir0=0 then dir1=1
        start_op(1000, 0);
        chk("op1_busy", busy, 1);
        wait_result(lat);
        chk("op1_latency", lat, 18);
        chk_tol("op1_x_out", int'(x_out), 1647, 4);
        chk("op1_dir_lo", dir_out[1:0], 2'b10);
        chk("op1_quad", quad_flip, 0);
        @(posedge clk); #1;
        chk("op1_pulse_end", out_valid, 0);

        // (3000,4000): |v|=5000, first three directions 0,0,1
        start_op(3000, 4000);
        wait_result(lat);
        chk("op2_latency", lat, 18);
        chk_tol("op2_x_out", int'(x_out), 8234, 4);
        chk("op2_dir_lo", dir_out[2:0], 3'b100);
        chk("op2_quad", quad_flip, 0);

        // (-3000,4000): pre-rotated to (3000,-4000), directions mirror
        start_op(-3000, 4000);
        wait_result(lat);
        chk("op3_latency", lat, 18);
        chk_tol("op3_x_out", int'(x_out), 8234, 4);
        chk("op3_dir_lo", dir_out[2:0], 3'b011);
        chk("op3_quad", quad_flip, 1);

        // Asynchronous reset while ITER is at cnt=7
        start_op(1000, 0);
        repeat (8) @(posedge clk);
        #2;
        chk("abort_busy_pre", busy, 1);
        nreset = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_x_out",     x_out,     0);
        chk("abort_dir_out",   dir_out,   0);
        chk("abort_quad",      quad_flip, 0);
        chk("abort_busy",      busy,      0);
        @(negedge clk);
        nreset = 1'b1;
        start_op(3000, 4000);
        wait_result(lat);
        chk("post_rst_latency", lat, 18);
        chk_tol("post_rst_x_out", int'(x_out), 8234, 4);
        chk("post_rst_dir_lo", dir_out[2:0], 3'b100);

        // Zero vector
        start_op(0, 0);
        wait_result(lat);
        chk("zero_latency", lat, 18);
        chk("zero_x_out", x_out, 0);
        chk("zero_dir", dir_out, 16'h0000);
        chk("zero_quad", quad_flip, 0);

        // Most negative x: saturating negation, wrapping result, must stay known
        start_op(-2097152, 0);
        wait_result(lat);
        chk("minneg_latency", lat, 18);
        chk("minneg_known", $isunknown({x_out, dir_out}), 0);
        chk("minneg_quad", quad_flip, 1);

        // Back-pressure: hold 10 cycles with a stray request that must be ignored
        @(negedge clk);
        out_ready = 1'b0;
        start_op(3000, 4000);
        wait_result(lat);
        chk("stall_latency", lat, 18);
        xs = x_out;
        ds = dir_out;
        chk_tol("stall_x_out", int'(xs), 8234, 4);
        @(negedge clk);
        x_in     = W'(123);
        y_in     = W'(456);
        in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            chk("stall_valid",    out_valid, 1);
            chk("stall_x_hold",   x_out,     xs);
            chk("stall_dir_hold", dir_out,   ds);
            chk("stall_in_ready", in_ready,  0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall_release_valid", out_valid, 0);
        chk("stall_release_ready", in_ready,  1);
        chk("stall_release_busy",  busy,      0);
        chk("stall_release_x",     x_out,     xs);

        // Continuous in_valid: accepts every 19 cycles, one result per accept
        x_in     = W'(1000);
        y_in     = W'(0);
        in_valid = 1'b1;
        res_cnt  = 0;
        last_acc = -100;
        for (int cyc = 1; cyc <= 57; cyc++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) begin
                acc_cyc.push_back(cyc);
                last_acc = cyc;
            end
            if (out_valid) begin
                res_cnt++;
                chk("stream_res_cycle", cyc, last_acc + 18);
                chk_tol("stream_x_out", int'(x_out), 1647, 4);
            end
        end
        in_valid = 1'b0;
        chk("stream_accepts", acc_cyc.size(), 3);
        chk("stream_results", res_cnt, 3);
        if (acc_cyc.size() >= 3) begin
            chk("stream_gap0", acc_cyc[1] - acc_cyc[0], 19);
            chk("stream_gap1", acc_cyc[2] - acc_cyc[1], 19);
        end
        @(posedge clk); #1;
        chk("stream_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
